// File: rtl/hazard_ctrl.sv
// Generic stall/flush priority network with stale I-fetch response tracking.
// Optional performance counters are built when HAZARD_CTRL_PERF_EN is defined.
module hazard_ctrl #(
  parameter int NSTAGE   = 8,
  parameter int MAX_PEND = 2,
  localparam int PW      = $clog2(MAX_PEND + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NSTAGE-1:0] stall_req,
  input  logic [NSTAGE-1:0] redir_req,
  input  logic              commit_excp,
  input  logic              fetch_wait,
  input  logic              fetch_resp,
  output logic [NSTAGE-1:0] stall,
  output logic [NSTAGE-1:0] flush,
  output logic              redir_que,
  output logic              resp_drop,
  output logic [PW-1:0]     pend_cnt,
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_redir,
  output logic [31:0]       perf_drop
);

  logic [NSTAGE-1:0] anyReq;
  logic [NSTAGE-1:0] winOneHot;
  logic [NSTAGE-1:0] belowMask;
  logic              seen;
  logic              winStall;
  logic              winRedir;
  logic              redirAccepted;
  logic              pendFull;
  logic              pendInc;
  logic              pendDec;

  assign anyReq = stall_req | redir_req;

  // Scan from commit downward: the first requester found wins, everything below it is masked.
  always_comb begin
    winOneHot = '0;
    belowMask = '0;
    seen      = 1'b0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      if (seen) begin
        belowMask[i] = 1'b1;
      end
      if (!seen && anyReq[i]) begin
        seen         = 1'b1;
        winOneHot[i] = 1'b1;
      end
    end
  end

  assign winStall      = |(winOneHot & stall_req);
  assign winRedir      = (|winOneHot) & ~winStall;
  assign redirAccepted = commit_excp | winRedir;
  assign pendFull      = (pend_cnt == PW'(MAX_PEND));

  // A saturated stale counter holds fetch, unless the commit exception is flushing everything.
  always_comb begin
    stall     = '0;
    flush     = '0;
    redir_que = 1'b0;
    if (commit_excp) begin
      flush     = '1;
      redir_que = 1'b1;
    end else if (winStall) begin
      stall = belowMask | winOneHot;
      flush = winOneHot << 1;
    end else if (winRedir) begin
      flush     = belowMask;
      redir_que = 1'b1;
    end
    if (pendFull && !commit_excp) begin
      stall[0] = 1'b1;
    end
  end

  assign resp_drop = fetch_resp & ((pend_cnt != '0) | redirAccepted);
  assign pendInc   = redirAccepted & fetch_wait;
  assign pendDec   = fetch_resp & (pend_cnt != '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_cnt <= '0;
    end else if (pendInc && !pendDec && !pendFull) begin
      pend_cnt <= pend_cnt + PW'(1);
    end else if (pendDec && !pendInc) begin
      pend_cnt <= pend_cnt - PW'(1);
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] perfStallQ;
  logic [31:0] perfRedirQ;
  logic [31:0] perfDropQ;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perfStallQ <= '0;
      perfRedirQ <= '0;
      perfDropQ  <= '0;
    end else begin
      if (|stall)        perfStallQ <= perfStallQ + 32'd1;
      if (redirAccepted) perfRedirQ <= perfRedirQ + 32'd1;
      if (resp_drop)     perfDropQ  <= perfDropQ + 32'd1;
    end
  end

  assign perf_stall = perfStallQ;
  assign perf_redir = perfRedirQ;
  assign perf_drop  = perfDropQ;
`else
  assign perf_stall = '0;
  assign perf_redir = '0;
  assign perf_drop  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (NSTAGE=8, MAX_PEND=2): vector table,
// hand sequences for the stale counter and reset, and randomized model checking.
module tb_hazard_ctrl;

  localparam int NS   = 8;
  localparam int MAXP = 2;

  logic          clk = 1'b0;
  logic          resetn;
  logic [NS-1:0] stallReq, redirReq;
  logic          excp, fetchWait, fetchResp;
  logic [NS-1:0] stall, flush;
  logic          redirQue, respDrop;
  logic [1:0]    pendCnt;
  logic [31:0]   perfStall, perfRedir, perfDrop;

  int passCount  = 0;
  int checkCount = 0;

  int mPend, mPerfStall, mPerfRedir, mPerfDrop;

  typedef struct {
    logic [7:0] sReq;
    logic [7:0] rReq;
    logic       ex;
    logic [7:0] eStall;
    logic [7:0] eFlush;
    logic       eQue;
  } vec_t;

  vec_t vecs[11];

  hazard_ctrl #(.NSTAGE(NS), .MAX_PEND(MAXP)) dut (
    .clk(clk), .resetn(resetn), .stall_req(stallReq), .redir_req(redirReq),
    .commit_excp(excp), .fetch_wait(fetchWait), .fetch_resp(fetchResp),
    .stall(stall), .flush(flush), .redir_que(redirQue), .resp_drop(respDrop),
    .pend_cnt(pendCnt), .perf_stall(perfStall), .perf_redir(perfRedir),
    .perf_drop(perfDrop)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference behaviour straight from the priority rules, using integer stage indices.
  task automatic modelComb(output logic [7:0] eStall, output logic [7:0] eFlush,
                           output logic eQue, output logic eDrop, output logic acc);
    int k = -1;
    int tmp;
    for (int i = 0; i < NS; i++) if (stallReq[i] || redirReq[i]) k = i;
    eStall = 0; eFlush = 0; eQue = 0; acc = 0;
    if (excp) begin
      eFlush = 8'hFF; eQue = 1; acc = 1;
    end else if (k >= 0) begin
      if (stallReq[k]) begin
        tmp = (1 << (k + 1)) - 1;
        eStall = tmp[7:0];
        if (k < NS - 1) begin
          tmp = 1 << (k + 1);
          eFlush = tmp[7:0];
        end
      end else begin
        tmp = (1 << k) - 1;
        eFlush = tmp[7:0];
        eQue = 1; acc = 1;
      end
    end
    if (mPend == MAXP && !excp) eStall[0] = 1'b1;
    eDrop = fetchResp && (mPend != 0 || acc);
  endtask

  task automatic modelReset();
    mPend = 0; mPerfStall = 0; mPerfRedir = 0; mPerfDrop = 0;
  endtask

  task automatic checkPerf(input string tag);
`ifdef HAZARD_CTRL_PERF_EN
    checkOutput({tag, ".perfStall"}, perfStall, mPerfStall);
    checkOutput({tag, ".perfRedir"}, perfRedir, mPerfRedir);
    checkOutput({tag, ".perfDrop"},  perfDrop,  mPerfDrop);
`else
    checkOutput({tag, ".perfStall"}, perfStall, 32'd0);
    checkOutput({tag, ".perfRedir"}, perfRedir, 32'd0);
    checkOutput({tag, ".perfDrop"},  perfDrop,  32'd0);
`endif
  endtask

  // Drive one cycle, compare at the falling edge, then advance the model on the rising edge.
  task automatic applyStimulus(input string tag, input logic [7:0] s, input logic [7:0] r,
                               input logic e, input logic w, input logic f);
    logic [7:0] eS, eF;
    logic eQ, eD, acc;
    int nxt;
    stallReq = s; redirReq = r; excp = e; fetchWait = w; fetchResp = f;
    @(negedge clk);
    modelComb(eS, eF, eQ, eD, acc);
    checkOutput({tag, ".stall"}, stall, eS);
    checkOutput({tag, ".flush"}, flush, eF);
    checkOutput({tag, ".redirQue"}, redirQue, eQ);
    checkOutput({tag, ".respDrop"}, respDrop, eD);
    checkOutput({tag, ".pendCnt"}, pendCnt, mPend);
    checkPerf(tag);
    @(posedge clk);
    nxt = mPend;
    if (acc && w) nxt++;
    if (f && mPend > 0) nxt--;
    if (nxt > MAXP) nxt = MAXP;
    mPend = nxt;
    if (eS != 0) mPerfStall++;
    if (acc) mPerfRedir++;
    if (eD) mPerfDrop++;
    #1;
  endtask

  initial begin
    vecs[0]  = '{8'h10, 8'h00, 1'b0, 8'h1F, 8'h20, 1'b0};
    vecs[1]  = '{8'h08, 8'h20, 1'b0, 8'h00, 8'h1F, 1'b1};
    vecs[2]  = '{8'h80, 8'h00, 1'b1, 8'h00, 8'hFF, 1'b1};
    vecs[3]  = '{8'h80, 8'h00, 1'b0, 8'hFF, 8'h00, 1'b0};
    vecs[4]  = '{8'h00, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1};
    vecs[5]  = '{8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[6]  = '{8'h04, 8'h04, 1'b0, 8'h07, 8'h08, 1'b0};
    vecs[7]  = '{8'h03, 8'h40, 1'b0, 8'h00, 8'h3F, 1'b1};
    vecs[8]  = '{8'h00, 8'h80, 1'b0, 8'h00, 8'h7F, 1'b1};
    vecs[9]  = '{8'h01, 8'h00, 1'b0, 8'h01, 8'h02, 1'b0};
    vecs[10] = '{8'h00, 8'h00, 1'b1, 8'h00, 8'hFF, 1'b1};

    resetn = 1'b0;
    stallReq = 0; redirReq = 0; excp = 0; fetchWait = 0; fetchResp = 0;
    modelReset();
    #12;
    checkOutput("reset.pendCnt", pendCnt, 2'd0);
    checkOutput("reset.stall", stall, 8'h00);
    checkPerf("reset");
    resetn = 1'b1;

    for (int i = 0; i < 11; i++) begin
      stallReq = vecs[i].sReq; redirReq = vecs[i].rReq; excp = vecs[i].ex;
      fetchWait = 0; fetchResp = 0;
      @(negedge clk);
      checkOutput($sformatf("vec%0d.stall", i), stall, vecs[i].eStall);
      checkOutput($sformatf("vec%0d.flush", i), flush, vecs[i].eFlush);
      checkOutput($sformatf("vec%0d.redirQue", i), redirQue, vecs[i].eQue);
      applyStimulus($sformatf("vec%0d.model", i), vecs[i].sReq, vecs[i].rReq, vecs[i].ex, 1'b0, 1'b0);
    end

    // Two stale fetches saturate the counter, then drain one response at a time.
    applyStimulus("pend.redir1", 8'h00, 8'h20, 1'b0, 1'b1, 1'b0);
    applyStimulus("pend.redir2", 8'h00, 8'h20, 1'b0, 1'b1, 1'b0);
    checkOutput("pend.reach2", pendCnt, 2'd2);
    applyStimulus("pend.full", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    stallReq = 0; redirReq = 0; fetchResp = 1; #1;
    checkOutput("pend.forcedStall0", stall, 8'h01);
    checkOutput("pend.drop1", respDrop, 1'b1);
    applyStimulus("pend.resp1", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("pend.reach1", pendCnt, 2'd1);
    fetchResp = 0; #1;
    checkOutput("pend.released", stall, 8'h00);
    applyStimulus("pend.resp2", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("pend.reach0", pendCnt, 2'd0);

    // Saturated counter with a commit exception: stall[0] released, increment lost.
    applyStimulus("sat.a", 8'h00, 8'h02, 1'b0, 1'b1, 1'b0);
    applyStimulus("sat.b", 8'h00, 8'h02, 1'b0, 1'b1, 1'b0);
    applyStimulus("sat.excp", 8'h80, 8'h00, 1'b1, 1'b1, 1'b0);
    checkOutput("sat.held", pendCnt, 2'd2);
    applyStimulus("sat.drain1", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    applyStimulus("sat.drain2", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);

    // Redirect, new stale fetch and a returning response in one cycle: net unchanged.
    applyStimulus("same.setup", 8'h00, 8'h08, 1'b0, 1'b1, 1'b0);
    applyStimulus("same.cycle", 8'h00, 8'h08, 1'b0, 1'b1, 1'b1);
    checkOutput("same.stay1", pendCnt, 2'd1);

    resetn = 1'b0;
    #2;
    checkOutput("asyncReset.pendCnt", pendCnt, 2'd0);
    modelReset();
    checkPerf("asyncReset");
    #2;
    resetn = 1'b1;

    for (int i = 0; i < 5; i++) applyStimulus("perf.stall", 8'h04, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("perf.redir", 8'h00, 8'h10, 1'b0, 1'b0, 1'b0);
`ifdef HAZARD_CTRL_PERF_EN
    checkOutput("perf.stall5", perfStall, 32'd5);
    checkOutput("perf.redir3", perfRedir, 32'd3);
`else
    checkOutput("perf.stallOff", perfStall, 32'd0);
    checkOutput("perf.redirOff", perfRedir, 32'd0);
`endif

    for (int i = 0; i < 400; i++) begin
      logic [7:0] s, r;
      s = 8'($urandom & $urandom & $urandom);
      r = 8'($urandom & $urandom & $urandom);
      applyStimulus($sformatf("rand%0d", i), s, r, $urandom_range(0, 15) == 0,
                    1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
